// File: rtl/alu_unit_pkg.sv
// rtl/alu_unit_pkg.sv - opcode, funct3 and width constants shared by the ALU stage
package alu_unit_pkg;

    localparam int ROB_W = 5;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational integer/branch compute for one issued instruction
module alu_core
    import alu_unit_pkg::*;
(
    input  logic [6:0]  instr_type,
    input  logic [3:0]  op,
    input  logic [31:0] v1,
    input  logic [31:0] v2,
    output logic [31:0] value
);

    logic [2:0]  funct3;
    logic [4:0]  shamt;
    logic        alt;
    logic        is_r;
    logic        taken;
    logic [31:0] arith;

    assign funct3 = op[2:0];
    assign shamt  = v2[4:0];
    assign alt    = op[3];
    assign is_r   = (instr_type == OP_R);

    always_comb begin
        arith = 32'd0;
        case (funct3)
            F3_ADD:  arith = (is_r && alt) ? (v1 - v2) : (v1 + v2);
            F3_SLL:  arith = v1 << shamt;
            F3_SLT:  arith = {31'd0, $signed(v1) < $signed(v2)};
            F3_SLTU: arith = {31'd0, v1 < v2};
            F3_XOR:  arith = v1 ^ v2;
            // op[3] selects arithmetic shift for both R and I forms
            F3_SR:   arith = alt ? 32'($signed(v1) >>> shamt) : (v1 >> shamt);
            F3_OR:   arith = v1 | v2;
            F3_AND:  arith = v1 & v2;
            default: arith = 32'd0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (v1 == v2);
            F3_BNE:  taken = (v1 != v2);
            F3_BLT:  taken = ($signed(v1) < $signed(v2));
            F3_BGE:  taken = ($signed(v1) >= $signed(v2));
            F3_BLTU: taken = (v1 < v2);
            F3_BGEU: taken = (v1 >= v2);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        value = v1 + v2;
        if (instr_type == OP_R || instr_type == OP_I) begin
            value = arith;
        end else if (instr_type == OP_B) begin
            value = {31'd0, taken};
        end
    end

endmodule

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - ALU execution stage with result FIFO feeding the CDB
module alu_unit
    import alu_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ROB_W = alu_unit_pkg::ROB_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             _clear,
    input  logic             _alu_ready,
    input  logic [ROB_W-1:0] _alu_rob_id,
    input  logic [6:0]       _alu_type,
    input  logic [3:0]       _alu_op,
    input  logic [31:0]      _alu_v1,
    input  logic [31:0]      _alu_v2,
    output logic             _alu_full,
    input  logic             _cdb_grant,
    output logic             _cdb_ready,
    output logic [ROB_W-1:0] _cdb_rob_id,
    output logic [31:0]      _cdb_value,
    output logic             _alu_overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      core_value;
    logic [ROB_W-1:0] rob_mem [DEPTH];
    logic [31:0]      val_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             full;
    logic             empty;
    logic             active;
    logic             push;
    logic             pop;

    alu_core u_core (
        .instr_type (_alu_type),
        .op         (_alu_op),
        .v1         (_alu_v1),
        .v2         (_alu_v2),
        .value      (core_value)
    );

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign active = rdy_in && !_clear;
    assign push   = active && _alu_ready && !full;
    assign pop    = active && _cdb_grant && !empty;

    // Flush wins over pause so a mispredict empties the queue even while frozen
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (_clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (_alu_ready && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            rob_mem[tail] <= _alu_rob_id;
            val_mem[tail] <= core_value;
        end
    end

    assign _alu_full     = full;
    assign _alu_overflow = overflow;
    assign _cdb_ready    = !empty;
    assign _cdb_rob_id   = empty ? '0 : rob_mem[head];
    assign _cdb_value    = empty ? 32'd0 : val_mem[head];

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - directed self-checking bench for alu_unit
module tb_alu_unit;

    localparam logic [6:0] T_R = 7'b0110011;
    localparam logic [6:0] T_I = 7'b0010011;
    localparam logic [6:0] T_B = 7'b1100011;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        _clear;
    logic        _alu_ready;
    logic [4:0]  _alu_rob_id;
    logic [6:0]  _alu_type;
    logic [3:0]  _alu_op;
    logic [31:0] _alu_v1;
    logic [31:0] _alu_v2;
    logic        _alu_full;
    logic        _cdb_grant;
    logic        _cdb_ready;
    logic [4:0]  _cdb_rob_id;
    logic [31:0] _cdb_value;
    logic        _alu_overflow;

    int checks = 0;
    int errors = 0;

    alu_unit #(.DEPTH(4), .ROB_W(5)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        ._clear        (_clear),
        ._alu_ready    (_alu_ready),
        ._alu_rob_id   (_alu_rob_id),
        ._alu_type     (_alu_type),
        ._alu_op       (_alu_op),
        ._alu_v1       (_alu_v1),
        ._alu_v2       (_alu_v2),
        ._alu_full     (_alu_full),
        ._cdb_grant    (_cdb_grant),
        ._cdb_ready    (_cdb_ready),
        ._cdb_rob_id   (_cdb_rob_id),
        ._cdb_value    (_cdb_value),
        ._alu_overflow (_alu_overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_issue(input logic [4:0] rob, input logic [6:0] t, input logic [3:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        _alu_ready  = 1'b1;
        _alu_rob_id = rob;
        _alu_type   = t;
        _alu_op     = op;
        _alu_v1     = a;
        _alu_v2     = b;
    endtask

    task automatic issue(input logic [4:0] rob, input logic [6:0] t, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        set_issue(rob, t, op, a, b);
        tick();
        _alu_ready = 1'b0;
    endtask

    task automatic grant_one();
        _cdb_grant = 1'b1;
        tick();
        _cdb_grant = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [6:0] t, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        issue(5'd7, t, op, a, b);
        chk(tag, _cdb_value, exp);
        grant_one();
        chk({tag, "_popped"}, {31'd0, _cdb_ready}, 32'd0);
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; _clear = 1'b0; _alu_ready = 1'b0;
        _alu_rob_id = '0; _alu_type = '0; _alu_op = '0; _alu_v1 = '0; _alu_v2 = '0;
        _cdb_grant = 1'b0;
        tick(); tick();
        chk("rst_ready", {31'd0, _cdb_ready}, 32'd0);
        chk("rst_full", {31'd0, _alu_full}, 32'd0);
        chk("rst_ovf", {31'd0, _alu_overflow}, 32'd0);
        chk("rst_rob", {27'd0, _cdb_rob_id}, 32'd0);
        chk("rst_val", _cdb_value, 32'd0);
        rst_in = 1'b1;
        tick();

        // basic add and latency
        set_issue(5'd3, T_R, 4'b0000, 32'd5, 32'd7);
        #1;
        chk("no_bypass", {31'd0, _cdb_ready}, 32'd0);
        tick();
        _alu_ready = 1'b0;
        chk("add_ready", {31'd0, _cdb_ready}, 32'd1);
        chk("add_rob", {27'd0, _cdb_rob_id}, 32'd3);
        chk("add_val", _cdb_value, 32'd12);
        tick();
        chk("held_val", _cdb_value, 32'd12);
        grant_one();
        chk("add_popped", {31'd0, _cdb_ready}, 32'd0);
        grant_one();
        chk("empty_grant", {31'd0, _cdb_ready}, 32'd0);

        // op coverage
        do_op("sub",   T_R, 4'b1000, 32'd5, 32'd7, 32'hFFFF_FFFE);
        do_op("srai",  T_I, 4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000);
        do_op("addi8", T_I, 4'b1000, 32'd1, 32'd2, 32'd3);
        do_op("blt",   T_B, 4'b0100, 32'hFFFF_FFFF, 32'd1, 32'd1);
        do_op("bltu",  T_B, 4'b0110, 32'hFFFF_FFFF, 32'd1, 32'd0);
        do_op("sll",   T_R, 4'b0001, 32'd3, 32'h0000_0024, 32'd48);
        do_op("srl",   T_R, 4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000);
        do_op("slt",   T_R, 4'b0010, 32'hFFFF_FFFE, 32'd1, 32'd1);
        do_op("sltu",  T_I, 4'b0011, 32'hFFFF_FFFE, 32'd1, 32'd0);
        do_op("xor",   T_R, 4'b0100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
        do_op("and",   T_I, 4'b0111, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
        do_op("or",    T_R, 4'b0110, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
        do_op("bne",   T_B, 4'b0001, 32'd4, 32'd4, 32'd0);
        do_op("bgeu",  T_B, 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1);
        do_op("b010",  T_B, 4'b0010, 32'd1, 32'd1, 32'd0);
        do_op("other", 7'b0000011, 4'b0111, 32'hFFFF_FFFF, 32'd2, 32'd1);

        // fill to full, then overflow
        for (int i = 1; i <= 4; i++) begin
            issue(5'(i), T_R, 4'b0000, 32'(i), 32'd100);
        end
        chk("full_set", {31'd0, _alu_full}, 32'd1);
        chk("ovf_before", {31'd0, _alu_overflow}, 32'd0);
        issue(5'd5, T_R, 4'b0000, 32'd5, 32'd100);
        chk("ovf_set", {31'd0, _alu_overflow}, 32'd1);
        chk("full_hold", {31'd0, _alu_full}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_rob", {27'd0, _cdb_rob_id}, 32'(i));
            chk("drain_val", _cdb_value, 32'(i + 100));
            grant_one();
        end
        chk("drain_empty", {31'd0, _cdb_ready}, 32'd0);
        chk("drain_nfull", {31'd0, _alu_full}, 32'd0);

        // simultaneous push and pop with pointer wrap
        issue(5'd10, T_R, 4'b0000, 32'd10, 32'd0);
        issue(5'd11, T_R, 4'b0000, 32'd11, 32'd0);
        for (int k = 0; k < 5; k++) begin
            set_issue(5'(12 + k), T_R, 4'b0000, 32'(12 + k), 32'd0);
            _cdb_grant = 1'b1;
            chk("pp_rob", {27'd0, _cdb_rob_id}, 32'(10 + k));
            chk("pp_val", _cdb_value, 32'(10 + k));
            tick();
        end
        _alu_ready = 1'b0;
        _cdb_grant = 1'b0;
        chk("pp_nfull", {31'd0, _alu_full}, 32'd0);
        chk("pp_head", {27'd0, _cdb_rob_id}, 32'd15);
        grant_one();
        chk("pp_next", {27'd0, _cdb_rob_id}, 32'd16);
        grant_one();
        chk("pp_empty", {31'd0, _cdb_ready}, 32'd0);

        // flush
        issue(5'd20, T_R, 4'b0000, 32'd20, 32'd0);
        issue(5'd21, T_R, 4'b0000, 32'd21, 32'd0);
        issue(5'd22, T_R, 4'b0000, 32'd22, 32'd0);
        set_issue(5'd23, T_R, 4'b0000, 32'd23, 32'd0);
        _cdb_grant = 1'b1;
        _clear = 1'b1;
        tick();
        _clear = 1'b0; _cdb_grant = 1'b0; _alu_ready = 1'b0;
        chk("flush_ready", {31'd0, _cdb_ready}, 32'd0);
        chk("flush_full", {31'd0, _alu_full}, 32'd0);
        chk("flush_rob", {27'd0, _cdb_rob_id}, 32'd0);
        chk("ovf_sticky", {31'd0, _alu_overflow}, 32'd1);
        issue(5'd9, T_R, 4'b0000, 32'd9, 32'd0);
        chk("post_flush_rob", {27'd0, _cdb_rob_id}, 32'd9);
        grant_one();

        // pause
        issue(5'd24, T_R, 4'b0000, 32'd24, 32'd0);
        issue(5'd25, T_R, 4'b0000, 32'd25, 32'd0);
        rdy_in = 1'b0;
        set_issue(5'd26, T_R, 4'b0000, 32'd26, 32'd0);
        _cdb_grant = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("pause_rob", {27'd0, _cdb_rob_id}, 32'd24);
            chk("pause_val", _cdb_value, 32'd24);
        end
        _alu_ready = 1'b0;
        rdy_in = 1'b1;
        tick();
        chk("resume_rob", {27'd0, _cdb_rob_id}, 32'd25);
        tick();
        _cdb_grant = 1'b0;
        chk("resume_empty", {31'd0, _cdb_ready}, 32'd0);

        // clear while paused
        issue(5'd27, T_R, 4'b0000, 32'd27, 32'd0);
        rdy_in = 1'b0;
        _clear = 1'b1;
        tick();
        _clear = 1'b0;
        rdy_in = 1'b1;
        chk("pause_clear", {31'd0, _cdb_ready}, 32'd0);

        // asynchronous reset mid-operation
        issue(5'd28, T_R, 4'b0000, 32'd28, 32'd0);
        #2;
        rst_in = 1'b0;
        #1;
        chk("async_ready", {31'd0, _cdb_ready}, 32'd0);
        chk("async_ovf", {31'd0, _alu_overflow}, 32'd0);
        chk("async_val", _cdb_value, 32'd0);
        rst_in = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
